// File: rtl/memory_dma_ctrl.sv
// memory_dma_ctrl: 160-byte block-copy DMA from {SRC,00..9F} to FE00..FE9F, triggered by a CPU write to 0xFF46
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   cpu_address_bus       CPU address (16 bits)
//   cpu_nread/cpu_nwrite  CPU strobes, active-low
//   mem_address_bus       address presented to memory devices
//   mem_nread/mem_nwrite  memory strobes, active-low
//   data_bus              shared bidirectional 8-bit system data bus
//   dma_active            high while a transfer is in progress
//   cpu_blocked           high when the current CPU access is suppressed
//
// Optional feature: define DMA_ECHO_REMAP_EN to fold source pages 0xE0-0xFF onto 0xC0-0xDF.
module memory_dma_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_address_bus,
    input  logic        cpu_nread,
    input  logic        cpu_nwrite,
    output logic [15:0] mem_address_bus,
    output logic        mem_nread,
    output logic        mem_nwrite,
    inout  wire  [7:0]  data_bus,
    output logic        dma_active,
    output logic        cpu_blocked
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;
    localparam logic [7:0] LAST  = 8'd159;

    logic [1:0] state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] latch_q, latch_d;
    logic [7:0] src_q, src_d;
    logic [7:0] src_eff;
    logic       reg_hit, src_wr, cpu_access;

    assign reg_hit    = cpu_address_bus == 16'hFF46;
    assign src_wr     = reg_hit && !cpu_nwrite;
    assign cpu_access = !cpu_nread || !cpu_nwrite;

`ifdef DMA_ECHO_REMAP_EN
    assign src_eff = src_q >= 8'hE0 ? src_q - 8'h20 : src_q;
`else
    assign src_eff = src_q;
`endif

    always_comb begin
        state_d = state_q == START ? READ :
                  state_q == READ  ? WRITE :
                  state_q == WRITE ? (idx_q == LAST ? IDLE : READ) : IDLE;
        idx_d   = (state_q == WRITE && idx_q != LAST) ? idx_q + 8'd1 : idx_q;
        latch_d = state_q == READ ? data_bus : latch_q;
        src_d   = src_q;
        // A register write restarts the transfer from any state, including the last WRITE.
        if (src_wr) begin
            src_d   = data_bus;
            state_d = START;
            idx_d   = 8'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 8'd0;
            latch_q <= 8'h00;
            src_q   <= 8'hFF;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            latch_q <= latch_d;
            src_q   <= src_d;
        end
    end

    always_comb begin
        dma_active      = state_q != IDLE;
        // Only the high page 0xFF80-0xFFFF and the DMA register stay usable during a transfer.
        cpu_blocked     = dma_active && cpu_access && cpu_address_bus < 16'hFF80 && !reg_hit;
        mem_address_bus = state_q == WRITE ? {8'hFE, idx_q} :
                          dma_active       ? {src_eff, idx_q} : cpu_address_bus;
        mem_nread       = dma_active ? state_q != READ  : (cpu_nread  || reg_hit);
        mem_nwrite      = dma_active ? state_q != WRITE : (cpu_nwrite || reg_hit);
    end

    assign data_bus = state_q == WRITE         ? latch_q :
                      (!cpu_nread && reg_hit)  ? src_q   : 8'hzz;
endmodule

// File: doc/memory_dma_ctrl.md
MEMORY_DMA_CTRL -- requirements
Module: memory_dma_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clock in, reset in.
REQ-002 SHALL have ports:
  clock  input  1  system clock; all state changes on posedge
  reset  input  1  synchronous, active-high reset
  cpu_address_bus  input  16  CPU address
  cpu_nread  input  1  CPU read strobe, active-low
  cpu_nwrite  input  1  CPU write strobe, active-low
  mem_address_bus  output  16  address to memory devices
  mem_nread  output  1  memory read strobe, active-low
  mem_nwrite  output  1  memory write strobe, active-low
  data_bus  inout  8  shared system data bus
  dma_active  output  1  high while a transfer is in progress
  cpu_blocked  output  1  high when the current CPU access is suppressed

Function
REQ-003 SHALL hold an 8-bit source register (SRC) mapped at 0xFF46; a CPU write is sampled at posedge when cpu_nwrite=0 and cpu_address_bus=0xFF46, with SRC<=data_bus.
REQ-004 SHALL drive SRC onto data_bus when cpu_nread=0, cpu_address_bus=0xFF46 and state is not WRITE; data_bus SHALL be Z in all other undriven cases.
REQ-005 SHALL never forward 0xFF46 accesses to the memory bus (mem_nread=mem_nwrite=1 for them).
REQ-006 SHALL implement states IDLE, START, READ, WRITE with an 8-bit byte index IDX (0..159) and an 8-bit byte latch.
REQ-007 IDLE: mem_address_bus=cpu_address_bus, mem_nread=cpu_nread, mem_nwrite=cpu_nwrite (combinational pass-through); dma_active=0; cpu_blocked=0.
REQ-008 A 0xFF46 write in any state SHALL set IDX<=0 and state<=START on the same posedge (write during a transfer restarts it with the new SRC).
REQ-009 START: one cycle, mem_nread=mem_nwrite=1; next state READ.
REQ-010 READ: mem_address_bus={SRC_EFF,IDX}, mem_nread=0, mem_nwrite=1; at posedge latch<=data_bus; next state WRITE.
REQ-011 WRITE: mem_address_bus=0xFE00+IDX, mem_nwrite=0, mem_nread=1, data_bus driven with latch; at posedge, if IDX=159 next state IDLE, else IDX<=IDX+1 and next state READ.
REQ-012 Transfer length SHALL be exactly 160 bytes; dma_active=1 in START/READ/WRITE, i.e. 321 cycles after the triggering write.
REQ-013 While dma_active=1, CPU accesses (cpu_nread=0 or cpu_nwrite=0) with address in 0x0000-0xFF7F other than 0xFF46 SHALL assert cpu_blocked combinationally and SHALL NOT reach the memory bus; 0xFF80-0xFFFF and 0xFF46 SHALL NOT assert cpu_blocked.
REQ-014 A 0xFF46 write coinciding with the final WRITE cycle SHALL take priority: transfer restarts (START), not IDLE.

Reset
REQ-015 reset=1 at posedge SHALL force state IDLE, IDX=0, latch=0x00, SRC=0xFF, overriding any concurrent 0xFF46 write.
REQ-016 After reset: dma_active=0, cpu_blocked=0, memory bus in pass-through, data_bus Z unless REQ-004 applies; a transfer in progress SHALL be abandoned with no further memory write.

Configuration
REQ-017 Macro DMA_ECHO_REMAP_EN defined: SRC_EFF = SRC-0x20 when SRC is 0xE0-0xFF (echo area folds onto WRAM 0xC0-0xDF), else SRC.
REQ-018 Macro DMA_ECHO_REMAP_EN undefined: SRC_EFF = SRC for all values.

Verification
REQ-019 Reset then idle: CPU read 0xFF46 -> data_bus=0xFF; CPU read 0xC000 -> mem_address_bus=0xC000, mem_nread=0; dma_active=0.
REQ-020 Preload 0xC105=0xAB, write 0xC1 to 0xFF46 -> dma_active=1 next cycle; reads C100..C19F, writes FE00..FE9F in order; 0xFE05 becomes 0xAB; dma_active falls exactly 321 cycles after the write.
REQ-021 During transfer, CPU read 0xC000 -> cpu_blocked=1, mem bus shows DMA address; CPU read 0xFF90 -> cpu_blocked=0; CPU read 0xFF46 -> 0xC1.
REQ-022 At IDX=50 write 0xC2 to 0xFF46 -> START, next READ at 0xC200, 160 further bytes to FE00..FE9F.
REQ-023 Assert reset at IDX=80 -> next cycle IDLE, dma_active=0, no write to 0xFE50 or beyond.
REQ-024 Write 0xE3 to 0xFF46 -> first READ at 0xC300 with DMA_ECHO_REMAP_EN defined, 0xE300 without.
